ula_arbiter: RTL and testbench

- Two-requester round-robin front end for the shared ULA datapath (ops: add, sub, >, <, >=, <=, ==).
- Latches the winning requester's operands and opcode, drives the ULA for exactly one cycle, and captures the 9-bit result.
- Returns the result on a single valid/ready response channel tagged with the requester id.
- Sits between the control units that need ALU service and the single ULA instance; the ULA stays external and combinational.

---
 rtl/ula_arbiter.sv | 110 +++++++++++
 tb/tb_ula_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for the shared combinational ULA.
// Issues one op at a time and returns its result on a valid/ready channel.
module ula_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] A0,
    input  logic [N-1:0] B0,
    input  logic [2:0]   op0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] B1,
    input  logic [2:0]   op1,
    output logic         gnt1,
    output logic [N-1:0] ula_A,
    output logic [N-1:0] ula_B,
    output logic [2:0]   ula_selec,
    output logic         ula_en,
    input  logic [N:0]   ula_S,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N:0]   rsp_data,
    output logic         rsp_id,
    output logic         rsp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, ERR, RESP} state_t;

    localparam logic [2:0] OP_RSVD = 3'b111;

    state_t         state;
    logic           last_grant;

    logic           any_req_c;
    logic           win_c;
    logic [N-1:0]   win_a_c;
    logic [N-1:0]   win_b_c;
    logic [2:0]     win_op_c;

    // Winner selection: on contention the requester not granted last time wins.
    always_comb begin
        any_req_c = req0 | req1;
        win_c     = (req0 & req1) ? ~last_grant : req1;
        win_a_c   = win_c ? A1 : A0;
        win_b_c   = win_c ? B1 : B0;
        win_op_c  = win_c ? op1 : op0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            ula_A      <= '0;
            ula_B      <= '0;
            ula_selec  <= '0;
            ula_en     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        ula_A      <= win_a_c;
                        ula_B      <= win_b_c;
                        ula_selec  <= win_op_c;
                        gnt0       <= ~win_c;
                        gnt1       <= win_c;
                        last_grant <= win_c;
                        rsp_id     <= win_c;
                        // Reserved opcode bypasses the ULA entirely.
                        if (win_op_c == OP_RSVD) begin
                            state <= ERR;
                        end else begin
                            ula_en <= 1'b1;
                            state  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_data  <= ula_S;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    ula_en    <= 1'b0;
                    state     <= RESP;
                end
                ERR: begin
                    rsp_data  <= '0;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_arbiter.sv
// Randomised scoreboard bench for ula_arbiter with a behavioural ULA and
// a transaction-level round-robin model.
module tb_ula_arbiter;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [N-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic [2:0]   op0 = '0, op1 = '0;
    logic         gnt0, gnt1;
    logic [N-1:0] ula_A, ula_B;
    logic [2:0]   ula_selec;
    logic         ula_en;
    logic [N:0]   ula_S;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [N:0]   rsp_data;
    logic         rsp_id;
    logic         rsp_err;

    typedef struct {
        logic       id;
        logic [N:0] data;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   ready_mode = 0;    // 0: always ready, 1: random, 2: held low
    logic lg = 1'b1;         // model of last granted requester

    ula_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .A0(A0), .B0(B0), .op0(op0), .gnt0(gnt0),
        .req1(req1), .A1(A1), .B1(B1), .op1(op1), .gnt1(gnt1),
        .ula_A(ula_A), .ula_B(ula_B), .ula_selec(ula_selec), .ula_en(ula_en),
        .ula_S(ula_S),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [N:0] ula_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return (N+1)'(a > b);
            3'd3:    return (N+1)'(a < b);
            3'd4:    return (N+1)'(a >= b);
            3'd5:    return (N+1)'(a <= b);
            3'd6:    return (N+1)'(a == b);
            default: return '0;
        endcase
    endfunction

    // External ULA: output is forced to zero unless enabled, so a missing issue shows up.
    assign ula_S = ula_en ? ula_ref(ula_A, ula_B, ula_selec) : '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_exp(input logic id, input logic [N:0] data, input logic err);
        exp_t e;
        e.id = id; e.data = data; e.err = err;
        q.push_back(e);
    endtask

    // Monitor: drives rsp_ready and compares every presented response with the queue head.
    initial begin : monitor
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
            if (!rst && rsp_valid) begin
                if (q.size() == 0) begin
                    fail("unexpected_rsp");
                end else begin
                    check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                    check("rsp_data", 32'(rsp_data), 32'(q[0].data));
                    check("rsp_err", 32'(rsp_err), 32'(q[0].err));
                    if (rsp_ready) void'(q.pop_front());
                end
            end
            if (!rst && ula_en) begin
                check("en_on_reserved", 32'(ula_selec == 3'b111), 32'd0);
                if (prev_en) fail("ula_en_two_cycles");
            end
            prev_en = ula_en;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"}, 32'(gnt0), 32'd0);
        check({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        check({tag, "_ula_A"}, 32'(ula_A), 32'd0);
        check({tag, "_ula_B"}, 32'(ula_B), 32'd0);
        check({tag, "_ula_selec"}, 32'(ula_selec), 32'd0);
        check({tag, "_ula_en"}, 32'(ula_en), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        q.delete();
        lg = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    task automatic set_ready_mode(input int m);
        @(posedge clk);
        #1 ready_mode = m;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        set_ready_mode(0);
        while ((q.size() > 0 || rsp_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (q.size() > 0 || rsp_valid) fail("drain_timeout");
        @(negedge clk);
    endtask

    // which: 0 = gnt0, 1 = gnt1, 2 = rsp_valid
    task automatic wait_for(input int which, input string name);
        int cyc;
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 50) begin
            @(negedge clk);
            cyc++;
            hit = (which == 0) ? gnt0 : (which == 1) ? gnt1 : rsp_valid;
        end
        if (!hit) fail(name);
    endtask

    // Present one or both requests; the model predicts grant order and expected results.
    task automatic run_pair(input bit r0, input bit r1,
                            input logic [N-1:0] a0, input logic [N-1:0] b0, input logic [2:0] o0,
                            input logic [N:0] e0,
                            input logic [N-1:0] a1, input logic [N-1:0] b1, input logic [2:0] o1,
                            input logic [N:0] e1);
        bit want[$];
        bit w;
        int cyc;
        @(negedge clk);
        A0 = a0; B0 = b0; op0 = o0; req0 = r0;
        A1 = a1; B1 = b1; op1 = o1; req1 = r1;
        if (r0 && r1) begin
            w = !lg;
            want.push_back(w);
            want.push_back(!w);
            lg = !w;
        end else begin
            w = r1;
            want.push_back(w);
            lg = w;
        end
        foreach (want[i]) begin
            if (want[i]) push_exp(1'b1, e1, o1 == 3'b111);
            else         push_exp(1'b0, e0, o0 == 3'b111);
        end
        cyc = 0;
        while (want.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (gnt0 || gnt1) begin
                check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
                check("gnt_id", 32'(gnt1), 32'(want[0]));
                check("ula_A", 32'(ula_A), 32'(want[0] ? a1 : a0));
                check("ula_B", 32'(ula_B), 32'(want[0] ? b1 : b0));
                check("ula_selec", 32'(ula_selec), 32'(want[0] ? o1 : o0));
                if (gnt0) req0 = 1'b0;
                if (gnt1) req1 = 1'b0;
                void'(want.pop_front());
            end
        end
        if (want.size() > 0) begin
            fail("gnt_timeout");
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    initial begin : driver
        logic [N-1:0] ra0, rb0, ra1, rb1;
        logic [2:0]   ro0, ro1;
        bit           r0, r1;

        do_reset();

        // Single add: exact latency of gnt, ula_en and rsp_valid.
        @(negedge clk);
        A0 = 8'd55; B0 = 8'd10; op0 = 3'd0; req0 = 1'b1;
        push_exp(1'b0, 9'd65, 1'b0);
        lg = 1'b0;
        @(negedge clk);
        check("t1_gnt0", 32'(gnt0), 32'd1);
        check("t1_en", 32'(ula_en), 32'd1);
        check("t1_valid_early", 32'(rsp_valid), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        check("t1_gnt0_pulse", 32'(gnt0), 32'd0);
        check("t1_en_off", 32'(ula_en), 32'd0);
        check("t1_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("t1_valid_drop", 32'(rsp_valid), 32'd0);

        // Contention straight after reset, then alternation.
        do_reset();
        run_pair(1, 1, 8'd55, 8'd10, 3'd1, 9'd45, 8'd55, 8'd100, 3'd2, 9'd0);
        run_pair(1, 1, 8'd7, 8'd9, 3'd3, 9'd1, 8'd9, 8'd7, 3'd4, 9'd1);
        drain();

        // Backpressure holds the response and blocks new grants.
        set_ready_mode(2);
        @(negedge clk);
        A1 = 8'd10; B1 = 8'd10; op1 = 3'd6; req1 = 1'b1;
        push_exp(1'b1, 9'd1, 1'b0);
        lg = 1'b1;
        wait_for(1, "t3_gnt1_timeout");
        req1 = 1'b0;
        wait_for(2, "t3_valid_timeout");
        A0 = 8'd3; B0 = 8'd4; op0 = 3'd3; req0 = 1'b1;
        push_exp(1'b0, 9'd1, 1'b0);
        lg = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_valid_held", 32'(rsp_valid), 32'd1);
            check("t3_no_gnt", 32'(gnt0), 32'd0);
        end
        set_ready_mode(0);
        @(negedge clk);
        check("t3_no_gnt_resp", 32'(gnt0), 32'd0);
        @(negedge clk);
        check("t3_no_gnt_idle", 32'(gnt0), 32'd0);
        check("t3_valid_drop", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("t3_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        drain();

        // Reserved opcode.
        run_pair(1, 0, 8'd12, 8'd34, 3'd7, 9'd0, 8'd0, 8'd0, 3'd0, 9'd0);
        drain();

        // Asynchronous reset while a response is waiting.
        set_ready_mode(2);
        @(negedge clk);
        A0 = 8'd1; B0 = 8'd2; op0 = 3'd0; req0 = 1'b1;
        push_exp(1'b0, 9'd3, 1'b0);
        lg = 1'b0;
        wait_for(0, "t5_gnt0_timeout");
        req0 = 1'b0;
        wait_for(2, "t5_valid_timeout");
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        q.delete();
        lg = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        run_pair(1, 1, 8'd20, 8'd30, 3'd5, 9'd1, 8'd40, 8'd30, 3'd1, 9'd10);
        drain();

        // Add carry into bit N.
        run_pair(1, 0, 8'd200, 8'd100, 3'd0, 9'd300, 8'd0, 8'd0, 3'd0, 9'd0);
        drain();

        // Randomised traffic with random backpressure.
        set_ready_mode(1);
        for (int i = 0; i < 40; i++) begin
            r0  = 1'($urandom_range(0, 1));
            r1  = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            ra0 = N'($urandom); rb0 = N'($urandom); ro0 = 3'($urandom_range(0, 7));
            ra1 = N'($urandom); rb1 = N'($urandom); ro1 = 3'($urandom_range(0, 7));
            run_pair(r0, r1, ra0, rb0, ro0, ula_ref(ra0, rb0, ro0),
                     ra1, rb1, ro1, ula_ref(ra1, rb1, ro1));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
